// File: rtl/aukv_alu_sched.sv
// Two-requester front end for a single shared combinational ALU: round-robin grant,
// one operation in flight, result held until the consumer takes it.
module aukv_alu_sched (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req0_valid,
  input  logic [2:0]  i_req0_op,
  input  logic [31:0] i_req0_rs1,
  input  logic [31:0] i_req0_rs2,
  output logic        o_req0_ready,
  input  logic        i_req1_valid,
  input  logic [2:0]  i_req1_op,
  input  logic [31:0] i_req1_rs1,
  input  logic [31:0] i_req1_rs2,
  output logic        o_req1_ready,
  output logic [2:0]  o_alu_op,
  output logic [31:0] o_alu_rs1,
  output logic [31:0] o_alu_rs2,
  input  logic [31:0] i_alu_rd,
  output logic        o_rsp_valid,
  output logic        o_rsp_id,
  output logic [31:0] o_rsp_data,
  input  logic        i_rsp_ready,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic        rr_q, rr_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic        id_q, id_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        gnt0, gnt1;

  // Readies are gated by reset so an asserted valid cannot be acknowledged while in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && i_rstn) begin
      if (i_req0_valid && i_req1_valid) begin
        gnt0 = ~rr_q;
        gnt1 = rr_q;
      end else begin
        gnt0 = i_req0_valid;
        gnt1 = i_req1_valid;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    op_d        = op_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          op_d    = gnt1 ? i_req1_op  : i_req0_op;
          rs1_d   = gnt1 ? i_req1_rs1 : i_req0_rs1;
          rs2_d   = gnt1 ? i_req1_rs2 : i_req0_rs2;
          id_d    = gnt1;
          rr_d    = gnt0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = i_alu_rd;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      op_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      op_q        <= op_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;
  assign o_alu_op     = op_q;
  assign o_alu_rs1    = rs1_q;
  assign o_alu_rs2    = rs2_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_id     = id_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_busy       = (state_q != IDLE);

endmodule
